mux32_scan_sequencer: RTL and testbench
=======================================

Name: mux32_scan_sequencer

Overview:
- Upstream controller for the 32:1 single-bit multiplexor. Drives its 5-bit select and samples its 1-bit output.
- Steps the select through channels 0..31, waits a configurable settle time per channel, and captures each mux output bit into a 32-bit word.
- Hands the assembled word downstream with a valid/ready handshake.
- Supports single-shot and continuous scanning.

Parameters:
- SETTLE_CYCLES, 1, extra clocks `sel` is held before `mux_in` is sampled. Legal range 0..15. Each channel occupies SETTLE_CYCLES+1 clocks.

Ports:
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a scan; sampled only in IDLE
- continuous  input  1  1 = restart scan automatically after each word handshake; sampled at handshake
- sel  output  5  select to mux S input
- mux_in  input  1  mux F output
- word_out  output  32  assembled word; word_out[k] = mux_in sampled while sel==k
- word_valid  output  1  word_out holds a complete scan
- word_ready  input  1  downstream accepts word
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: synchronous, active-high; overrides everything, including mid-scan. On the edge with rst=1:
  - state <= IDLE
  - sel <= 0, word_out <= 0, word_valid <= 0, busy <= 0
  - settle counter <= 0, shadow word <= 0
- Outputs are registered; no combinational path from inputs to outputs.
- State machine: IDLE, SETTLE, SAMPLE, HOLD.
  - IDLE: sel=0. start=1 at edge E0 -> SETTLE, busy=1, sel=0, settle counter = SETTLE_CYCLES.
  - SETTLE: decrement counter each clock. When counter==0 -> SAMPLE. With SETTLE_CYCLES=0, go to SAMPLE on the next clock.
  - SAMPLE: one clock.
    - Shadow[sel] <= mux_in.
    - If sel!=31: sel <= sel+1, reload counter, -> SETTLE.
    - If sel==31: word_out <= shadow with bit 31 = mux_in, word_valid <= 1, -> HOLD. sel stays 31.
  - HOLD: word_out, word_valid and sel are held stable until word_valid && word_ready.
    - On handshake: word_valid <= 0.
    - If continuous=1: sel <= 0, reload counter, -> SETTLE, busy stays 1.
    - Else: -> IDLE, sel <= 0, busy <= 0.
- Timing:
  - Channel k is sampled at edge E0 + (k+1)(SETTLE_CYCLES+1).
  - word_valid rises after edge E0 + 32(SETTLE_CYCLES+1). Default: 64 clocks.
- Boundary conditions:
  - start while busy: ignored, no restart, no corruption.
  - start and rst in the same cycle: rst wins.
  - word_ready high before word_valid: no effect; the handshake needs both high.
  - word_ready already high when word_valid rises: handshake completes on the next edge, so valid is high for exactly 1 clock.
  - continuous changed mid-scan: only its value at the handshake edge matters.
  - sel wrap 31->0: only via HOLD handshake; sel never increments past 31.
  - Shadow word is not cleared between scans; every bit is overwritten each scan.
  - word_out changes only on the SAMPLE edge of channel 31 or on reset.

Test Plan:
1. Reset, SETTLE_CYCLES=1, mux model returning bit k of pattern 0xA5A50F0F when sel==k, start pulse, word_ready=1, continuous=0 -> sel steps 0..31 with each value held 2 clocks; word_valid high exactly 1 clock, 64 clocks after start; word_out=0xA5A50F0F; busy then 0 and sel=0.
2. Same pattern, word_ready held low 10 clocks after word_valid rises -> word_out=0xA5A50F0F, word_valid=1 and sel=31 stable all 10 clocks; handshake on the first ready-high edge; IDLE next.
3. continuous=1, pattern 0x12345678 then changed to 0xFFFF0000 during the first scan's HOLD; ready=1 -> first word 0x12345678, second word 0xFFFF0000 64 clocks after the first handshake; busy never drops.
4. start pulses at clocks 5 and 20 after the first accepted start -> only one scan; valid at +64 from the first start.
5. rst asserted 1 clock at channel 17 mid-scan -> next edge: sel=0, busy=0, word_valid=0, word_out=0. A following start with pattern 0xDEADBEEF yields 0xDEADBEEF.
6. SETTLE_CYCLES=0, pattern 0x80000001 -> sel advances every clock; valid 32 clocks after start; word_out=0x80000001.

Source files
------------

// File: rtl/mux32_scan_sequencer.sv
// Scan controller for a 32:1 single-bit mux: walks sel over channels 0..31,
// captures each mux output bit into a word, and hands it off with valid/ready.
module mux32_scan_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        continuous,
  output logic [4:0]  sel,
  input  logic        mux_in,
  output logic [31:0] word_out,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, HOLD} state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);
  // SETTLE covers the extra hold clocks and SAMPLE the last one, so a zero
  // settle time bypasses SETTLE and each channel still takes SETTLE_CYCLES+1.
  localparam state_t FIRST_STATE = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [31:0] shadow, shadow_n;
  logic [4:0]  sel_n;
  logic [31:0] word_n;
  logic        valid_n;
  logic        busy_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      shadow     <= '0;
      sel        <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      shadow     <= shadow_n;
      sel        <= sel_n;
      word_out   <= word_n;
      word_valid <= valid_n;
      busy       <= busy_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    shadow_n = shadow;
    sel_n    = sel;
    word_n   = word_out;
    valid_n  = word_valid;
    busy_n   = busy;

    case (state)
      IDLE: begin
        sel_n = '0;
        if (start) begin
          state_n = FIRST_STATE;
          cnt_n   = SETTLE_LOAD;
          busy_n  = 1'b1;
        end
      end

      SETTLE: begin
        cnt_n = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          state_n = SAMPLE;
        end
      end

      SAMPLE: begin
        shadow_n[sel] = mux_in;
        if (sel != 5'd31) begin
          sel_n   = sel + 5'd1;
          cnt_n   = SETTLE_LOAD;
          state_n = FIRST_STATE;
        end else begin
          word_n  = {mux_in, shadow[30:0]};
          valid_n = 1'b1;
          state_n = HOLD;
        end
      end

      HOLD: begin
        if (word_valid && word_ready) begin
          valid_n = 1'b0;
          sel_n   = '0;
          if (continuous) begin
            cnt_n   = SETTLE_LOAD;
            state_n = FIRST_STATE;
          end else begin
            state_n = IDLE;
            busy_n  = 1'b0;
          end
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mux32_scan_sequencer.sv
// Directed bench for mux32_scan_sequencer: one instance with the default
// settle time and one with zero settle time, each fed by a pattern-driven mux.
module tb_mux32_scan_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        start0 = 1'b0;
  logic        continuous = 1'b0;
  logic        word_ready = 1'b0;
  logic [31:0] pat = '0;
  logic [31:0] pat0 = '0;

  logic [4:0]  sel, sel0;
  logic        mux_in, mux_in0;
  logic [31:0] word_out, word_out0;
  logic        word_valid, word_valid0;
  logic        busy, busy0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign mux_in  = pat[sel];
  assign mux_in0 = pat0[sel0];

  mux32_scan_sequencer #(.SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous),
    .sel(sel), .mux_in(mux_in), .word_out(word_out), .word_valid(word_valid),
    .word_ready(word_ready), .busy(busy)
  );

  mux32_scan_sequencer #(.SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .continuous(continuous),
    .sel(sel0), .mux_in(mux_in0), .word_out(word_out0), .word_valid(word_valid0),
    .word_ready(word_ready), .busy(busy0)
  );

  // Advance past the next rising edge; drives and samples happen 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({sel, word_valid, busy} !== 7'd0 || word_out !== 32'd0) begin
      failures++;
      $display("FAIL reset_state: sel=%0d valid=%b busy=%b word=%h, required 0/0/0/00000000",
               sel, word_valid, busy, word_out);
    end
    checks++;
    if ({sel0, word_valid0, busy0} !== 7'd0 || word_out0 !== 32'd0) begin
      failures++;
      $display("FAIL reset_state0: sel=%0d valid=%b busy=%b word=%h, required 0/0/0/00000000",
               sel0, word_valid0, busy0, word_out0);
    end
  endtask

  task automatic test_single_shot();
    int bad = 0;
    pat = 32'hA5A50F0F;
    word_ready = 1'b1;
    continuous = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || sel !== 5'd0) begin
      failures++;
      $display("FAIL single_start: busy=%b sel=%0d, required 1/0", busy, sel);
    end
    for (int n = 1; n <= 63; n++) begin
      tick();
      if (sel !== 5'(n / 2) || word_valid !== 1'b0 || busy !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL single_sel_steps: %0d bad cycles, required 0", bad);
    end
    tick();
    checks++;
    if (word_valid !== 1'b1 || word_out !== 32'hA5A50F0F || sel !== 5'd31) begin
      failures++;
      $display("FAIL single_word: valid=%b word=%h sel=%0d, required 1/a5a50f0f/31",
               word_valid, word_out, sel);
    end
    tick();
    checks++;
    if (word_valid !== 1'b0 || busy !== 1'b0 || sel !== 5'd0 || word_out !== 32'hA5A50F0F) begin
      failures++;
      $display("FAIL single_after: valid=%b busy=%b sel=%0d word=%h, required 0/0/0/a5a50f0f",
               word_valid, busy, sel, word_out);
    end
  endtask

  task automatic test_backpressure();
    int bad = 0;
    pat = 32'hA5A50F0F;
    word_ready = 1'b0;
    continuous = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (64) tick();
    checks++;
    if (word_valid !== 1'b1 || word_out !== 32'hA5A50F0F) begin
      failures++;
      $display("FAIL bp_valid: valid=%b word=%h, required 1/a5a50f0f", word_valid, word_out);
    end
    for (int n = 0; n < 10; n++) begin
      tick();
      if (word_valid !== 1'b1 || word_out !== 32'hA5A50F0F || sel !== 5'd31 || busy !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL bp_hold_stable: %0d bad cycles, required 0", bad);
    end
    word_ready = 1'b1;
    tick();
    checks++;
    if (word_valid !== 1'b0 || busy !== 1'b0 || sel !== 5'd0) begin
      failures++;
      $display("FAIL bp_handshake: valid=%b busy=%b sel=%0d, required 0/0/0",
               word_valid, busy, sel);
    end
  endtask

  task automatic test_continuous();
    int busy_drops = 0;
    int early = 0;
    pat = 32'h12345678;
    word_ready = 1'b1;
    continuous = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 64; n++) begin
      tick();
      if (busy !== 1'b1) busy_drops++;
    end
    checks++;
    if (word_valid !== 1'b1 || word_out !== 32'h12345678) begin
      failures++;
      $display("FAIL cont_word1: valid=%b word=%h, required 1/12345678", word_valid, word_out);
    end
    pat = 32'hFFFF0000;
    tick();
    checks++;
    if (word_valid !== 1'b0 || busy !== 1'b1 || sel !== 5'd0) begin
      failures++;
      $display("FAIL cont_restart: valid=%b busy=%b sel=%0d, required 0/1/0",
               word_valid, busy, sel);
    end
    for (int n = 1; n <= 63; n++) begin
      tick();
      if (busy !== 1'b1) busy_drops++;
      if (word_valid !== 1'b0) early++;
    end
    tick();
    checks++;
    if (word_valid !== 1'b1 || word_out !== 32'hFFFF0000 || early !== 0) begin
      failures++;
      $display("FAIL cont_word2: valid=%b word=%h early=%0d, required 1/ffff0000/0",
               word_valid, word_out, early);
    end
    checks++;
    if (busy_drops !== 0) begin
      failures++;
      $display("FAIL cont_busy: %0d cycles with busy low, required 0", busy_drops);
    end
    continuous = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || word_valid !== 1'b0) begin
      failures++;
      $display("FAIL cont_stop: busy=%b valid=%b, required 0/0", busy, word_valid);
    end
  endtask

  task automatic test_start_while_busy();
    int early = 0;
    pat = 32'h0F0F3C3C;
    word_ready = 1'b1;
    continuous = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 63; n++) begin
      start = (n == 5 || n == 20);
      tick();
      if (word_valid !== 1'b0) early++;
      if (n == 6) begin
        checks++;
        if (sel !== 5'd3) begin
          failures++;
          $display("FAIL restart_ignored: sel=%0d, required 3", sel);
        end
      end
    end
    start = 1'b0;
    tick();
    checks++;
    if (word_valid !== 1'b1 || word_out !== 32'h0F0F3C3C || early !== 0) begin
      failures++;
      $display("FAIL busy_start_word: valid=%b word=%h early=%0d, required 1/0f0f3c3c/0",
               word_valid, word_out, early);
    end
    tick();
  endtask

  task automatic test_reset_midscan();
    pat = 32'h11111111;
    word_ready = 1'b1;
    continuous = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (34) tick();
    checks++;
    if (sel !== 5'd17) begin
      failures++;
      $display("FAIL midscan_sel: sel=%0d, required 17", sel);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (sel !== 5'd0 || busy !== 1'b0 || word_valid !== 1'b0 || word_out !== 32'd0) begin
      failures++;
      $display("FAIL midscan_reset: sel=%0d busy=%b valid=%b word=%h, required 0/0/0/00000000",
               sel, busy, word_valid, word_out);
    end
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_beats_start: busy=%b, required 0", busy);
    end
    pat = 32'hDEADBEEF;
    tick();
    start = 1'b0;
    repeat (64) tick();
    checks++;
    if (word_valid !== 1'b1 || word_out !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL post_reset_word: valid=%b word=%h, required 1/deadbeef", word_valid, word_out);
    end
    tick();
  endtask

  task automatic test_settle_zero();
    int bad = 0;
    pat0 = 32'h80000001;
    word_ready = 1'b1;
    continuous = 1'b0;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int n = 1; n <= 31; n++) begin
      tick();
      if (sel0 !== 5'(n) || word_valid0 !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL s0_sel_steps: %0d bad cycles, required 0", bad);
    end
    tick();
    checks++;
    if (word_valid0 !== 1'b1 || word_out0 !== 32'h80000001 || sel0 !== 5'd31) begin
      failures++;
      $display("FAIL s0_word: valid=%b word=%h sel=%0d, required 1/80000001/31",
               word_valid0, word_out0, sel0);
    end
    tick();
    checks++;
    if (word_valid0 !== 1'b0 || busy0 !== 1'b0 || sel0 !== 5'd0) begin
      failures++;
      $display("FAIL s0_after: valid=%b busy=%b sel=%0d, required 0/0/0",
               word_valid0, busy0, sel0);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_single_shot();
    test_backpressure();
    test_continuous();
    test_start_while_busy();
    test_reset_midscan();
    test_settle_zero();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
